// File: rtl/cmd_sequencer_pkg.sv
// Shared types for the SD command sequencer: response types, CMD12 index, FSM states.
package cmd_sequencer_pkg;

  typedef enum logic [1:0] {
    RSP_NONE    = 2'd0,
    RSP_136     = 2'd1,
    RSP_48      = 2'd2,
    RSP_48_BUSY = 2'd3
  } rsp_type_e;

  localparam logic [5:0] CMD12_INDEX = 6'd12;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT_CMD = 3'd2,
    WAIT_RSP = 3'd3,
    FINISH   = 3'd4
  } state_e;

endpackage

// File: rtl/cmd_sequencer_if.sv
// Command sequencer bus: software command register, command engine and data path handshakes.
interface cmd_sequencer_if;
  import cmd_sequencer_pkg::*;

  logic        sd_clk_en_p_i;
  logic        sw_cmd_valid_i;
  logic [5:0]  sw_cmd_index_i;
  logic [31:0] sw_cmd_arg_i;
  rsp_type_e   sw_rsp_type_i;
  logic        sw_data_present_i;
  logic        auto12_req_i;
  logic        dat_done_i;
  logic        cmd_done_i;
  logic        rsp_done_i;

  logic        cmd_start_o;
  logic [5:0]  cmd_index_o;
  logic [31:0] cmd_arg_o;
  rsp_type_e   cmd_rsp_type_o;
  logic        cmd_inhibit_cmd_o;
  logic        cmd_inhibit_dat_o;
  logic        cmd_complete_o;
  logic        cmd_timeout_o;
  logic        auto12_done_o;
  logic        sw_cmd_rejected_o;

  modport slave (
    input  sd_clk_en_p_i, sw_cmd_valid_i, sw_cmd_index_i, sw_cmd_arg_i, sw_rsp_type_i,
           sw_data_present_i, auto12_req_i, dat_done_i, cmd_done_i, rsp_done_i,
    output cmd_start_o, cmd_index_o, cmd_arg_o, cmd_rsp_type_o, cmd_inhibit_cmd_o,
           cmd_inhibit_dat_o, cmd_complete_o, cmd_timeout_o, auto12_done_o, sw_cmd_rejected_o
  );

  modport master (
    output sd_clk_en_p_i, sw_cmd_valid_i, sw_cmd_index_i, sw_cmd_arg_i, sw_rsp_type_i,
           sw_data_present_i, auto12_req_i, dat_done_i, cmd_done_i, rsp_done_i,
    input  cmd_start_o, cmd_index_o, cmd_arg_o, cmd_rsp_type_o, cmd_inhibit_cmd_o,
           cmd_inhibit_dat_o, cmd_complete_o, cmd_timeout_o, auto12_done_o, sw_cmd_rejected_o
  );

endinterface

// File: rtl/cmd_rsp_timer.sv
// Response timer: counts SD clock enable pulses while running, saturating at RspTimeout.
module cmd_rsp_timer #(
  parameter int unsigned RspTimeout = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run,
  input  logic clear,
  input  logic sd_clk_en_p_i,
  output logic expired
);

  localparam int unsigned W = $clog2(RspTimeout + 1);
  localparam logic [W-1:0] Limit = W'(RspTimeout);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (run && sd_clk_en_p_i && (count_q != Limit)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign expired = (count_q == Limit);

endmodule

// File: rtl/cmd_sequencer.sv
// SD host command sequencer: arbitrates software commands and auto CMD12, tracks CMD/DAT inhibit.
// Auto CMD12 support is built only when SDHCI_AUTO_CMD12_EN is defined.
module cmd_sequencer
  import cmd_sequencer_pkg::*;
#(
  parameter int unsigned RspTimeout = 64
) (
  input logic            clk_i,
  input logic            rst_i,
  cmd_sequencer_if.slave bus
);

  state_e      state_q;
  logic [5:0]  index_q;
  logic [31:0] arg_q;
  rsp_type_e   rsp_type_q;
  logic        has_data_q;
  logic        timeout_q;
  logic        inhibit_dat_q;
  logic        rejected_q;
  logic        expired;
  logic        auto12_go;
  logic        sw_accept;
  logic        rsp_timeout;

`ifdef SDHCI_AUTO_CMD12_EN
  logic auto12_pend_q;
  logic is_auto12_q;
  assign auto12_go = auto12_pend_q | bus.auto12_req_i;
`else
  assign auto12_go = 1'b0;
`endif

  assign sw_accept = bus.sw_cmd_valid_i && (state_q == IDLE) && !auto12_go &&
                     !(bus.sw_data_present_i && inhibit_dat_q);

  // rsp_done_i in the same cycle as expiry takes priority, so no timeout is raised
  assign rsp_timeout = (state_q == WAIT_RSP) && expired && !bus.rsp_done_i;

  cmd_rsp_timer #(.RspTimeout(RspTimeout)) u_timer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .run          (state_q == WAIT_RSP),
    .clear        (state_q == ISSUE),
    .sd_clk_en_p_i(bus.sd_clk_en_p_i),
    .expired      (expired)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      index_q       <= '0;
      arg_q         <= '0;
      rsp_type_q    <= RSP_NONE;
      has_data_q    <= 1'b0;
      timeout_q     <= 1'b0;
      inhibit_dat_q <= 1'b0;
      rejected_q    <= 1'b0;
`ifdef SDHCI_AUTO_CMD12_EN
      auto12_pend_q <= 1'b0;
      is_auto12_q   <= 1'b0;
`endif
    end else begin
      rejected_q <= bus.sw_cmd_valid_i && !sw_accept;

`ifdef SDHCI_AUTO_CMD12_EN
      if ((state_q != IDLE) && bus.auto12_req_i) auto12_pend_q <= 1'b1;
`endif

      if (sw_accept && bus.sw_data_present_i) begin
        inhibit_dat_q <= 1'b1;
      end else if (bus.dat_done_i || (rsp_timeout && has_data_q)) begin
        inhibit_dat_q <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
`ifdef SDHCI_AUTO_CMD12_EN
          if (auto12_go) begin
            index_q       <= CMD12_INDEX;
            arg_q         <= '0;
            rsp_type_q    <= RSP_48_BUSY;
            has_data_q    <= 1'b0;
            is_auto12_q   <= 1'b1;
            auto12_pend_q <= 1'b0;
            state_q       <= ISSUE;
          end else
`endif
          if (sw_accept) begin
            index_q    <= bus.sw_cmd_index_i;
            arg_q      <= bus.sw_cmd_arg_i;
            rsp_type_q <= bus.sw_rsp_type_i;
            has_data_q <= bus.sw_data_present_i;
            state_q    <= ISSUE;
          end
        end
        ISSUE: state_q <= WAIT_CMD;
        WAIT_CMD: begin
          if (bus.cmd_done_i) state_q <= (rsp_type_q == RSP_NONE) ? FINISH : WAIT_RSP;
        end
        WAIT_RSP: begin
          if (bus.rsp_done_i) begin
            state_q <= FINISH;
          end else if (expired) begin
            timeout_q <= 1'b1;
            state_q   <= FINISH;
          end
        end
        FINISH: begin
          timeout_q <= 1'b0;
`ifdef SDHCI_AUTO_CMD12_EN
          is_auto12_q <= 1'b0;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_start_o       = (state_q == ISSUE);
  assign bus.cmd_index_o       = index_q;
  assign bus.cmd_arg_o         = arg_q;
  assign bus.cmd_rsp_type_o    = rsp_type_q;
  assign bus.cmd_inhibit_cmd_o = (state_q != IDLE);
  assign bus.cmd_inhibit_dat_o = inhibit_dat_q;
  assign bus.cmd_timeout_o     = (state_q == FINISH) && timeout_q;
  assign bus.sw_cmd_rejected_o = rejected_q;
`ifdef SDHCI_AUTO_CMD12_EN
  assign bus.cmd_complete_o    = (state_q == FINISH) && !is_auto12_q;
  assign bus.auto12_done_o     = (state_q == FINISH) && is_auto12_q;
`else
  assign bus.cmd_complete_o    = (state_q == FINISH);
  assign bus.auto12_done_o     = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_sequencer.sv
// Scoreboard bench for cmd_sequencer (RspTimeout=4); auto CMD12 checks follow SDHCI_AUTO_CMD12_EN.
module tb_cmd_sequencer;
  import cmd_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmd_sequencer_if bus();

  cmd_sequencer #(.RspTimeout(4)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned a12_starts = 0;
  logic [39:0] start_q[$];   // {index, arg, rsp_type}
  logic [2:0]  cpl_q[$];     // {auto12_done, complete, timeout}

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {17'd0, bus.cmd_start_o, bus.cmd_index_o, bus.cmd_arg_o, bus.cmd_rsp_type_o,
            bus.cmd_inhibit_cmd_o, bus.cmd_inhibit_dat_o, bus.cmd_complete_o,
            bus.cmd_timeout_o, bus.auto12_done_o, bus.sw_cmd_rejected_o};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cmd_start_o) begin
        if (bus.cmd_index_o == 6'd12 && bus.cmd_arg_o == 32'd0) a12_starts++;
        if (start_q.size() == 0) check_eq("start_unexpected", bus.cmd_start_o, 1'b0);
        else check_eq("start_cmd", {bus.cmd_index_o, bus.cmd_arg_o, bus.cmd_rsp_type_o},
                      start_q.pop_front());
      end
      if (bus.cmd_complete_o || bus.auto12_done_o) begin
        if (cpl_q.size() == 0)
          check_eq("cpl_unexpected", {bus.auto12_done_o, bus.cmd_complete_o}, 2'b00);
        else check_eq("cpl_kind", {bus.auto12_done_o, bus.cmd_complete_o, bus.cmd_timeout_o},
                      cpl_q.pop_front());
      end else if (bus.cmd_timeout_o) begin
        check_eq("timeout_orphan", bus.cmd_timeout_o, 1'b0);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue_sw(input logic [5:0] idx, input logic [31:0] arg, input rsp_type_e t,
                          input logic data);
    bus.sw_cmd_index_i    = idx;
    bus.sw_cmd_arg_i      = arg;
    bus.sw_rsp_type_i     = t;
    bus.sw_data_present_i = data;
    bus.sw_cmd_valid_i    = 1'b1;
    start_q.push_back({idx, arg, t});
    tick();
    bus.sw_cmd_valid_i    = 1'b0;
    bus.sw_data_present_i = 1'b0;
    check_eq("start_latency", bus.cmd_start_o, 1'b1);
  endtask

  task automatic cmd_done();
    bus.cmd_done_i = 1'b1;
    tick();
    bus.cmd_done_i = 1'b0;
  endtask

  task automatic sd_pulses(input int n);
    repeat (n) begin
      bus.sd_clk_en_p_i = 1'b1;
      tick();
      bus.sd_clk_en_p_i = 1'b0;
      tick();
    end
  endtask

  // late=0: rsp_done with the 4th pulse; late=1: rsp_done in the cycle the timer expires
  task automatic race(input logic late);
    issue_sw(6'd8, 32'h1, RSP_136, 1'b0);
    tick();
    cmd_done();
    sd_pulses(3);
    bus.sd_clk_en_p_i = 1'b1;
    if (late) begin
      tick();
      bus.sd_clk_en_p_i = 1'b0;
    end
    cpl_q.push_back(3'b010);
    bus.rsp_done_i = 1'b1;
    tick();
    bus.rsp_done_i    = 1'b0;
    bus.sd_clk_en_p_i = 1'b0;
    check_eq(late ? "race_late_timeout" : "race_4th_timeout",
             {bus.cmd_complete_o, bus.cmd_timeout_o}, 2'b10);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    bus.sd_clk_en_p_i = 1'b0;  bus.sw_cmd_valid_i = 1'b0;  bus.sw_cmd_index_i = '0;
    bus.sw_cmd_arg_i = '0;     bus.sw_rsp_type_i = RSP_NONE; bus.sw_data_present_i = 1'b0;
    bus.auto12_req_i = 1'b0;   bus.dat_done_i = 1'b0;      bus.cmd_done_i = 1'b0;
    bus.rsp_done_i = 1'b0;
    tick(2);
    check_eq("reset_outputs", outs(), 64'd0);
    rst = 1'b0;
    tick();

    // Data command with R48 response; DAT inhibit held until dat_done_i
    issue_sw(6'd17, 32'h200, RSP_48, 1'b1);
    check_eq("t1_arg", bus.cmd_arg_o, 32'h200);
    check_eq("t1_inhibits", {bus.cmd_inhibit_cmd_o, bus.cmd_inhibit_dat_o}, 2'b11);
    tick();
    cmd_done();
    sd_pulses(2);
    check_eq("t1_no_early_cpl", bus.cmd_complete_o, 1'b0);
    cpl_q.push_back(3'b010);
    bus.rsp_done_i = 1'b1;
    tick();
    bus.rsp_done_i = 1'b0;
    check_eq("t1_complete", {bus.cmd_complete_o, bus.cmd_timeout_o}, 2'b10);
    tick(3);
    check_eq("t1_dat_held", {bus.cmd_inhibit_cmd_o, bus.cmd_inhibit_dat_o}, 2'b01);
    bus.sw_cmd_index_i = 6'd24; bus.sw_data_present_i = 1'b1; bus.sw_cmd_valid_i = 1'b1;
    tick();
    bus.sw_cmd_valid_i = 1'b0; bus.sw_data_present_i = 1'b0;
    check_eq("dat_busy_reject", {bus.sw_cmd_rejected_o, bus.cmd_inhibit_cmd_o}, 2'b10);
    bus.dat_done_i = 1'b1;
    tick();
    bus.dat_done_i = 1'b0;
    check_eq("t1_dat_release", bus.cmd_inhibit_dat_o, 1'b0);

    // RSP_NONE: complete one cycle after cmd_done_i
    issue_sw(6'd0, 32'h0, RSP_NONE, 1'b0);
    tick();
    cpl_q.push_back(3'b010);
    cmd_done();
    check_eq("none_cpl_latency", bus.cmd_complete_o, 1'b1);
    tick();
    check_eq("none_idle", bus.cmd_inhibit_cmd_o, 1'b0);

    // Timeout after the 4th SD clock pulse; also releases DAT inhibit
    issue_sw(6'd8, 32'h1AA, RSP_48, 1'b1);
    tick();
    cmd_done();
    sd_pulses(3);
    check_eq("to_not_yet", bus.cmd_complete_o, 1'b0);
    bus.sd_clk_en_p_i = 1'b1;
    tick();
    bus.sd_clk_en_p_i = 1'b0;
    cpl_q.push_back(3'b011);
    tick();
    check_eq("to_cpl_timeout", {bus.cmd_complete_o, bus.cmd_timeout_o}, 2'b11);
    check_eq("to_dat_release", bus.cmd_inhibit_dat_o, 1'b0);
    tick();
    race(1'b0);
    race(1'b1);

    // Command rejected while busy; then reset abandons the in-flight command
    issue_sw(6'd5, 32'hABCD, RSP_48, 1'b0);
    tick();
    bus.sw_cmd_index_i = 6'd9; bus.sw_cmd_valid_i = 1'b1;
    tick();
    bus.sw_cmd_valid_i = 1'b0;
    check_eq("busy_reject", bus.sw_cmd_rejected_o, 1'b1);
    check_eq("busy_index_kept", bus.cmd_index_o, 6'd5);
    cmd_done();
    sd_pulses(1);
    rst = 1'b1;
    #1;
    check_eq("mid_reset_outputs", outs(), 64'd0);
    tick(2);
    rst = 1'b0;
    tick(6);
    check_eq("post_reset_quiet", outs(), 64'd0);

`ifdef SDHCI_AUTO_CMD12_EN
    // Three CMD12 requests during a command collapse to a single CMD12
    issue_sw(6'd18, 32'h40, RSP_48, 1'b1);
    tick();
    repeat (2) begin
      bus.auto12_req_i = 1'b1; tick(); bus.auto12_req_i = 1'b0; tick();
    end
    cmd_done();
    bus.auto12_req_i = 1'b1; tick(); bus.auto12_req_i = 1'b0;
    cpl_q.push_back(3'b010);
    bus.rsp_done_i = 1'b1;
    tick();
    bus.rsp_done_i = 1'b0;
    check_eq("a12_sw_complete", bus.cmd_complete_o, 1'b1);
    start_q.push_back({6'd12, 32'd0, RSP_48_BUSY});
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      if (bus.cmd_start_o) seen = 1'b1;
      else tick();
    end
    check_eq("a12_start_seen", seen, 1'b1);
    tick();
    cmd_done();
    cpl_q.push_back(3'b100);
    bus.rsp_done_i = 1'b1;
    tick();
    bus.rsp_done_i = 1'b0;
    check_eq("a12_done", {bus.auto12_done_o, bus.cmd_complete_o}, 2'b10);
    tick(6);
    check_eq("a12_once", a12_starts, 1);
    bus.dat_done_i = 1'b1; tick(); bus.dat_done_i = 1'b0;

    // CMD12 request beats a simultaneous software command
    bus.auto12_req_i = 1'b1; bus.sw_cmd_index_i = 6'd3; bus.sw_cmd_valid_i = 1'b1;
    start_q.push_back({6'd12, 32'd0, RSP_48_BUSY});
    tick();
    bus.auto12_req_i = 1'b0; bus.sw_cmd_valid_i = 1'b0;
    check_eq("a12_prio", {bus.sw_cmd_rejected_o, bus.cmd_start_o, bus.cmd_index_o}, {2'b11, 6'd12});
    tick();
    cmd_done();
    cpl_q.push_back(3'b100);
    bus.rsp_done_i = 1'b1; tick(); bus.rsp_done_i = 1'b0;
    tick(2);
`else
    bus.auto12_req_i = 1'b1; tick(); bus.auto12_req_i = 1'b0;
    tick(4);
    check_eq("a12_ignored", {bus.cmd_inhibit_cmd_o, bus.auto12_done_o}, 2'b00);
`endif

    check_eq("start_q_drained", start_q.size(), 0);
    check_eq("cpl_q_drained", cpl_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_sequencer.md
CMD_SEQUENCER -- requirements
Module: cmd_sequencer
Interface
REQ-001 SHALL have parameter RspTimeout, default 64, number of sd_clk_en_p_i pulses allowed in WAIT_RSP before timeout.
REQ-002 SHALL have port clk_i  in  1  single clock.
REQ-003 SHALL have port rst_i  in  1  asynchronous active-high reset.
REQ-004 SHALL have port sd_clk_en_p_i  in  1  SD clock rising-edge enable pulse.
REQ-005 SHALL have port sw_cmd_valid_i  in  1  software command write strobe (command register qe).
REQ-006 SHALL have port sw_cmd_index_i  in  6  software command index.
REQ-007 SHALL have port sw_cmd_arg_i  in  32  software command argument.
REQ-008 SHALL have port sw_rsp_type_i  in  2  software response type (rsp_type_e).
REQ-009 SHALL have port sw_data_present_i  in  1  software command has a data phase.
REQ-010 SHALL have port auto12_req_i  in  1  auto CMD12 request pulse from the data path.
REQ-011 SHALL have port dat_done_i  in  1  data transfer finished pulse.
REQ-012 SHALL have port cmd_done_i  in  1  command engine finished sending the command.
REQ-013 SHALL have port rsp_done_i  in  1  command engine received the full response.
REQ-014 SHALL have port cmd_start_o  out  1  one-cycle start pulse to command engine.
REQ-015 SHALL have port cmd_index_o  out  6  index of the command in flight.
REQ-016 SHALL have port cmd_arg_o  out  32  argument of the command in flight.
REQ-017 SHALL have port cmd_rsp_type_o  out  2  response type of the command in flight.
REQ-018 SHALL have port cmd_inhibit_cmd_o  out  1  CMD line busy.
REQ-019 SHALL have port cmd_inhibit_dat_o  out  1  DAT line reserved by a data command.
REQ-020 SHALL have port cmd_complete_o  out  1  software command complete pulse.
REQ-021 SHALL have port cmd_timeout_o  out  1  response timeout pulse, coincident with the completion pulse.
REQ-022 SHALL have port auto12_done_o  out  1  auto CMD12 complete pulse.
REQ-023 SHALL have port sw_cmd_rejected_o  out  1  software command dropped pulse.
Function
REQ-024 FSM SHALL have states IDLE, ISSUE, WAIT_CMD, WAIT_RSP, FINISH, plus flag is_auto12_q marking the command in flight as CMD12.
REQ-025 IDLE: auto12_pend_q or auto12_req_i SHALL go to ISSUE with index 12, arg 0, type RSP_48_BUSY; this beats a simultaneous sw_cmd_valid_i, which is rejected.
REQ-026 IDLE: an accepted sw_cmd_valid_i SHALL latch index, arg and type and go to ISSUE; sw_cmd_valid_i in cycle N gives cmd_start_o in cycle N+1.
REQ-027 ISSUE SHALL assert cmd_start_o for exactly one cycle, clear the timer and go to WAIT_CMD; cmd_index_o, cmd_arg_o and cmd_rsp_type_o stay stable from ISSUE until IDLE.
REQ-028 WAIT_CMD: cmd_done_i SHALL go to FINISH if type is RSP_NONE, otherwise to WAIT_RSP.
REQ-029 WAIT_RSP SHALL count sd_clk_en_p_i pulses.
REQ-030 WAIT_RSP: rsp_done_i SHALL go to FINISH; reaching count RspTimeout SHALL set timeout_q and go to FINISH; if both occur in the same cycle, rsp_done_i wins and no timeout is flagged.
REQ-031 FINISH SHALL pulse cmd_complete_o (software command) or auto12_done_o (is_auto12_q) for one cycle, with cmd_timeout_o if timeout_q is set, then go to IDLE.
REQ-032 sw_cmd_valid_i outside IDLE, or with sw_data_present_i while cmd_inhibit_dat_o=1, SHALL pulse sw_cmd_rejected_o in the next cycle and leave state unchanged.
REQ-033 auto12_req_i outside IDLE SHALL set auto12_pend_q; repeated requests collapse to one; the flag clears on entering ISSUE for CMD12.
REQ-034 cmd_inhibit_cmd_o SHALL equal (state != IDLE), decoded from registers only.
REQ-035 cmd_inhibit_dat_o SHALL set on acceptance of a data command and clear on dat_done_i or on that command's timeout; if set and dat_done_i occur in the same cycle, set wins.
REQ-036 The timer SHALL be $clog2(RspTimeout+1) bits wide and saturate, never wrap.
Reset
REQ-037 rst_i SHALL force IDLE, clear all flags, timer and latched fields to 0, and drive all outputs to 0; a reset mid-command SHALL abandon the command with no completion pulse and drop a pending CMD12.
Configuration
REQ-038 With SDHCI_AUTO_CMD12_EN defined, REQ-025 and REQ-033 SHALL apply; without it, auto12_req_i SHALL be ignored, auto12_pend_q and is_auto12_q SHALL not exist, and auto12_done_o SHALL be tied 0.
Structure
REQ-039 A shared package SHALL hold rsp_type_e (RSP_NONE=0, RSP_136=1, RSP_48=2, RSP_48_BUSY=3), the CMD12 index constant and the FSM state enum.
REQ-040 The response timer SHALL be a sub-module cmd_rsp_timer (inputs run, clear, sd_clk_en_p_i; output expired).
Verification
REQ-041 SHALL test: sw index 17, arg 32'h200, RSP_48, data=1 -> start 1 cycle later, cmd_arg_o=32'h200, cmd_complete_o after rsp_done_i, inhibit_dat held until dat_done_i.
REQ-042 SHALL test: RSP_NONE command -> cmd_complete_o 1 cycle after cmd_done_i, no WAIT_RSP.
REQ-043 SHALL test: RspTimeout=4, no rsp_done_i -> cmd_complete_o and cmd_timeout_o together after the 4th sd_clk_en_p_i; with rsp_done_i on the 4th -> no timeout.
REQ-044 SHALL test: auto12_req_i three times during a sw command -> exactly one CMD12 (index 12, arg 0) issued afterwards, auto12_done_o pulses once.
REQ-045 SHALL test: sw_cmd_valid_i in WAIT_CMD -> sw_cmd_rejected_o pulses, in-flight cmd_index_o unchanged; rst_i in WAIT_RSP -> all outputs 0, no completion pulse.
